mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Two-port arbiter/sequencer in front of the single-port MU0 memory (memRq/readNotWrite/addr/dataIn/dataOut).
//   Port 0 = CPU, port 1 = debug/program loader. Grants one requester at a time and latches its command.
//   Drives the memory strobe for a fixed number of cycles, then returns read data and a one-cycle ack.
// PARAMETERS
//   ADDR_W         16  address width, both ports and memory
//   DATA_W         16  data width, both ports and memory
//   ACCESS_CYCLES  1   cycles memRq is held per access (>=1); read data sampled on the last one
// PORTS
//   clk           in   1       system clock, rising edge
//   rst_n         in   1       synchronous reset, active low
//   p0_req        in   1       port 0 access request, level
//   p0_rnw        in   1       port 0: 1 = read, 0 = write
//   p0_addr       in   ADDR_W  port 0 address
//   p0_wdata      in   DATA_W  port 0 write data
//   p0_ack        out  1       port 0 access complete, 1-cycle pulse
//   p0_rdata      out  DATA_W  port 0 read data, valid with p0_ack and held until next p0 read
//   p1_*          same set as p0_* for port 1
//   memRq         out  1       memory request strobe
//   readNotWrite  out  1       memory direction: 1 = read, 0 = write
//   addr          out  ADDR_W  memory address
//   dataIn        out  DATA_W  memory write data
//   dataOut       in   DATA_W  memory read data
//   busy          out  1       high in ACCESS and ACK
//   grant_id      out  1       port owning the current or last access
// BEHAVIOUR
//   - Reset (rst_n low at posedge): state=IDLE; memRq=0; readNotWrite=1; addr, dataIn, p0_rdata, p1_rdata = 0;
//     p0_ack=p1_ack=0; busy=0; grant_id=0; cycle counter=0. Mid-access reset aborts at once; no ack issued.
//   - FSM: IDLE -> ACCESS -> ACK -> IDLE.
//   - IDLE: if any req at posedge, pick winner, latch rnw/addr/wdata and grant_id, go ACCESS. Else stay.
//   - ACCESS: memRq=1; readNotWrite/addr/dataIn come from latched regs, never from live port inputs.
//     Counter runs 0..ACCESS_CYCLES-1. On the last cycle, a read captures dataOut into the winner's
//     rdata reg; go ACK.
//   - ACK: memRq=0, readNotWrite=1; winner's ack=1 for exactly this cycle; go IDLE.
//   - Latency: req sampled at edge N -> ack high during cycle N+ACCESS_CYCLES+1. Max throughput one
//     access per ACCESS_CYCLES+2 cycles.
//   - Requester keeps req high until ack. Dropping req after grant does not cancel: the access
//     completes and ack still pulses. req still high in the IDLE cycle after ack = new request.
//   - Loser's req is only sampled in IDLE; it is never lost while held. No ack to the loser.
//   - The memory returns a non-zero default when memRq=0; rdata regs ignore dataOut outside the
//     capture cycle.
//   - Write: dataIn stable for all ACCESS cycles; rdata regs unchanged.
//   - Counter is $clog2(ACCESS_CYCLES)+1 bits wide and never wraps past ACCESS_CYCLES-1.
// CONFIGURATION
//   MEM_ARB_ROUND_ROBIN_EN defined: round-robin. On a tie the port that was not granted last wins
//     (last-grant reg resets to 1, so port 0 wins the first tie).
//   Undefined: fixed priority, port 0 always wins a tie; port 1 can starve.
//   Single requests behave the same in both modes.
// TESTING
//   1. Reset: rst_n=0 for 2 cycles -> memRq=0, acks=0, busy=0, rdata=0, readNotWrite=1.
//   2. p0 write 0x1F<-0x0055, then p0 read 0x1F -> memRq high ACCESS_CYCLES cycles each;
//      p0_ack at N+ACCESS_CYCLES+1; p0_rdata=0x0055.
//   3. p1 write 0x00<-0x00AA while p0 idle -> grant_id=1, p1_ack pulses once; p1 read 0x00
//      returns 0x00AA; p0_rdata unchanged.
//   4. p0 and p1 both hold req for 4 accesses -> RR: grants 0,1,0,1; fixed: 0,0,0,0 and p1_ack never pulses.
//   5. p0 drops req one cycle after grant -> access completes, one p0_ack, then IDLE with memRq=0.
//   6. rst_n=0 during ACCESS -> next cycle memRq=0, no ack; a fresh p0 read then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port MU0 memory.
// Port 0 is the CPU and port 1 is the debug/program loader. One requester is granted at a
// time. Its command is latched, the memory strobe is held for ACCESS_CYCLES cycles, and then
// a one-cycle ack is returned together with any read data.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to make ties round-robin. By default port 0
// has fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_rnw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_rnw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              memRq,
  output logic              readNotWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] dataOut,
  output logic              busy,
  output logic              grant_id
);

  localparam int unsigned CntW = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAck
  } stateT;

  stateT             stateQ, stateD;
  logic [CntW-1:0]   cntQ;
  logic              rnwQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              grantQ;
  logic [DATA_W-1:0] p0RdataQ, p1RdataQ;
  logic              anyReq;
  logic              winner;
  logic              lastAccess;

  assign anyReq     = p0_req | p1_req;
  assign lastAccess = (stateQ == StAccess) && (cntQ == CntLast);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Port that won most recently. It resets to 1 so that port 0 takes the first tie.
  logic lastGrantQ;

  // Choose the winner: a lone requester wins, and on a tie the port not granted last wins.
  always_comb begin
    winner = !p0_req;
    if (p0_req && p1_req) begin
      winner = !lastGrantQ;
    end
  end

  // Record which port received the latest grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastGrantQ <= 1'b1;
    end else if (stateQ == StIdle && anyReq) begin
      lastGrantQ <= winner;
    end
  end
`else
  // Choose the winner with fixed priority: port 0 takes every tie.
  always_comb begin
    winner = !p0_req;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic: IDLE -> ACCESS -> ACK -> IDLE.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (anyReq) stateD = StAccess;
      StAccess: if (cntQ == CntLast) stateD = StAck;
      StAck:    stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Outputs decoded from state. Memory direction rests at read whenever no access is active.
  always_comb begin
    memRq        = 1'b0;
    readNotWrite = 1'b1;
    busy         = 1'b0;
    p0_ack       = 1'b0;
    p1_ack       = 1'b0;
    unique case (stateQ)
      StAccess: begin
        memRq        = 1'b1;
        readNotWrite = rnwQ;
        busy         = 1'b1;
      end
      StAck: begin
        busy   = 1'b1;
        p0_ack = !grantQ;
        p1_ack = grantQ;
      end
      default: ;
    endcase
  end

  // Command latch, access counter and per-port read-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cntQ     <= '0;
      rnwQ     <= 1'b1;
      addrQ    <= '0;
      wdataQ   <= '0;
      grantQ   <= 1'b0;
      p0RdataQ <= '0;
      p1RdataQ <= '0;
    end else begin
      if (stateQ == StIdle) begin
        cntQ <= '0;
        if (anyReq) begin
          grantQ <= winner;
          rnwQ   <= winner ? p1_rnw   : p0_rnw;
          addrQ  <= winner ? p1_addr  : p0_addr;
          wdataQ <= winner ? p1_wdata : p0_wdata;
        end
      end else if (stateQ == StAccess && cntQ != CntLast) begin
        cntQ <= cntQ + CntW'(1);
      end
      // The memory drives a non-zero idle value, so dataOut is sampled only on this cycle.
      if (lastAccess && rnwQ) begin
        if (grantQ) begin
          p1RdataQ <= dataOut;
        end else begin
          p0RdataQ <= dataOut;
        end
      end
    end
  end

  assign addr     = addrQ;
  assign dataIn   = wdataQ;
  assign grant_id = grantQ;
  assign p0_rdata = p0RdataQ;
  assign p1_rdata = p1RdataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a memory model, scenario tasks and a randomized transaction run
// that is checked against a transaction-level reference memory.
module tb_mem_arbiter;

  localparam int AC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_rnw, p1_req, p1_rnw;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic        memRq, readNotWrite, busy, grant_id;
  logic [15:0] addr, dataIn, dataOut;

  int checks = 0;
  int passed = 0;

  logic [15:0] memArr [0:255];
  logic [15:0] refMem [int];
  logic [15:0] refRdata [2];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_rnw(p0_rnw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rnw(p1_rnw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .memRq(memRq), .readNotWrite(readNotWrite), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Single-port memory: combinational read, non-zero value while idle.
  assign dataOut = memRq ? memArr[addr[7:0]] : 16'hBEEF;
  always @(posedge clk) if (memRq && !readNotWrite) memArr[addr[7:0]] <= dataIn;

  task automatic setPort(input int port, input logic req, input logic rnw,
                         input logic [15:0] a, input logic [15:0] d);
    if (port == 0) begin
      p0_req = req; p0_rnw = rnw; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = req; p1_rnw = rnw; p1_addr = a; p1_wdata = d;
    end
  endtask

  // Drive one access from a negedge with the DUT idle, then observe for a fixed window.
  task automatic runAccess(input int port, input logic rnw, input logic [15:0] a,
                           input logic [15:0] d, input bit dropEarly, output int lat,
                           output int rqCycles, output int acks, output int otherAcks,
                           output logic [15:0] rd, output bit dinOk, output logic gid);
    int edges = 0;
    lat = -1; rqCycles = 0; acks = 0; otherAcks = 0; dinOk = 1; rd = 'x; gid = 'x;
    setPort(port, 1'b1, rnw, a, d);
    for (int i = 0; i < AC + 8; i++) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (memRq) begin
        rqCycles++;
        if (addr !== a || readNotWrite !== rnw || (!rnw && dataIn !== d)) dinOk = 0;
      end
      if ((port == 0) ? p0_ack : p1_ack) begin
        acks++;
        if (lat < 0) begin
          lat = edges; rd = (port == 0) ? p0_rdata : p1_rdata; gid = grant_id;
        end
      end
      if ((port == 0) ? p1_ack : p0_ack) otherAcks++;
      // Scramble live inputs after the grant: the access must use latched values only.
      if (lat < 0 && edges == 1) setPort(port, !dropEarly, ~rnw, ~a, ~d);
      if (lat >= 0) setPort(port, 1'b0, 1'b1, 16'h0, 16'h0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (memRq !== 1'b0) $display("FAIL reset_memRq: got %b, expected 0", memRq); else passed++;
    checks++; if ({p0_ack, p1_ack} !== 2'b00) $display("FAIL reset_acks: got %b, expected 00", {p0_ack, p1_ack}); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else passed++;
    checks++; if (readNotWrite !== 1'b1) $display("FAIL reset_rnw: got %b, expected 1", readNotWrite); else passed++;
    checks++; if ({p0_rdata, p1_rdata} !== 32'h0) $display("FAIL reset_rdata: got %h, expected 0", {p0_rdata, p1_rdata}); else passed++;
    checks++; if ({addr, dataIn, 15'h0, grant_id} !== 48'h0) $display("FAIL reset_addr_data_gid: got %h, expected 0", {addr, dataIn, 15'h0, grant_id}); else passed++;
    rst_n = 1'b1;
    refRdata[0] = 16'h0; refRdata[1] = 16'h0;
  endtask

  task automatic test_p0_write_read();
    int lat, rq, acks, oth; logic [15:0] rd; bit ok; logic gid;
    runAccess(0, 1'b0, 16'h001F, 16'h0055, 1'b0, lat, rq, acks, oth, rd, ok, gid);
    refMem[16'h001F] = 16'h0055;
    checks++; if (lat != AC + 1) $display("FAIL p0w_latency: got %0d, expected %0d", lat, AC + 1); else passed++;
    checks++; if (rq != AC) $display("FAIL p0w_memRq_cycles: got %0d, expected %0d", rq, AC); else passed++;
    checks++; if (!ok) $display("FAIL p0w_bus_stable: got 0, expected 1"); else passed++;
    checks++; if (rd !== 16'h0) $display("FAIL p0w_rdata_kept: got %h, expected 0000", rd); else passed++;
    runAccess(0, 1'b1, 16'h001F, 16'h0, 1'b0, lat, rq, acks, oth, rd, ok, gid);
    refRdata[0] = 16'h0055;
    checks++; if (lat != AC + 1) $display("FAIL p0r_latency: got %0d, expected %0d", lat, AC + 1); else passed++;
    checks++; if (rd !== 16'h0055) $display("FAIL p0r_rdata: got %h, expected 0055", rd); else passed++;
    checks++; if (acks != 1 || oth != 0) $display("FAIL p0r_ack_count: got %0d/%0d, expected 1/0", acks, oth); else passed++;
  endtask

  task automatic test_p1_access();
    int lat, rq, acks, oth; logic [15:0] rd; bit ok; logic gid;
    runAccess(1, 1'b0, 16'h0000, 16'h00AA, 1'b0, lat, rq, acks, oth, rd, ok, gid);
    refMem[16'h0000] = 16'h00AA;
    checks++; if (gid !== 1'b1) $display("FAIL p1w_grant_id: got %b, expected 1", gid); else passed++;
    checks++; if (acks != 1 || oth != 0) $display("FAIL p1w_ack_count: got %0d/%0d, expected 1/0", acks, oth); else passed++;
    runAccess(1, 1'b1, 16'h0000, 16'h0, 1'b0, lat, rq, acks, oth, rd, ok, gid);
    refRdata[1] = 16'h00AA;
    checks++; if (rd !== 16'h00AA) $display("FAIL p1r_rdata: got %h, expected 00aa", rd); else passed++;
    checks++; if (p0_rdata !== 16'h0055) $display("FAIL p1r_p0_rdata_kept: got %h, expected 0055", p0_rdata); else passed++;
  endtask

  task automatic test_contention();
    int order[$]; int expOrder[4]; int extra = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expOrder = '{0, 1, 0, 1};
`else
    expOrder = '{0, 0, 0, 0};
`endif
    setPort(0, 1'b1, 1'b1, 16'h001F, 16'h0);
    setPort(1, 1'b1, 1'b1, 16'h0000, 16'h0);
    for (int i = 0; i < 80 && extra < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (p0_ack) begin
        order.push_back(0);
        checks++; if (p0_rdata !== 16'h0055) $display("FAIL tie_p0_rdata: got %h, expected 0055", p0_rdata); else passed++;
      end
      if (p1_ack) begin
        order.push_back(1);
        checks++; if (p1_rdata !== 16'h00AA) $display("FAIL tie_p1_rdata: got %h, expected 00aa", p1_rdata); else passed++;
      end
      if (order.size() >= 4) begin
        setPort(0, 1'b0, 1'b1, 16'h0, 16'h0); setPort(1, 1'b0, 1'b1, 16'h0, 16'h0);
        extra++;
      end
    end
    checks++; if (order.size() != 4) $display("FAIL tie_grant_count: got %0d, expected 4", order.size()); else passed++;
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) begin
        checks++; if (order[k] != expOrder[k]) $display("FAIL tie_grant_%0d: got %0d, expected %0d", k, order[k], expOrder[k]); else passed++;
      end
    end
  endtask

  task automatic test_drop_req();
    int lat, rq, acks, oth; logic [15:0] rd; bit ok; logic gid;
    runAccess(0, 1'b1, 16'h0000, 16'h0, 1'b1, lat, rq, acks, oth, rd, ok, gid);
    refRdata[0] = 16'h00AA;
    checks++; if (acks != 1) $display("FAIL drop_ack_count: got %0d, expected 1", acks); else passed++;
    checks++; if (lat != AC + 1) $display("FAIL drop_latency: got %0d, expected %0d", lat, AC + 1); else passed++;
    checks++; if (rd !== 16'h00AA) $display("FAIL drop_rdata: got %h, expected 00aa", rd); else passed++;
    checks++; if (memRq !== 1'b0 || busy !== 1'b0) $display("FAIL drop_idle: got memRq=%b busy=%b, expected 0/0", memRq, busy); else passed++;
  endtask

  task automatic test_reset_mid_access();
    int lat, rq, acks, oth, stray = 0; logic [15:0] rd; bit ok; logic gid;
    setPort(0, 1'b1, 1'b1, 16'h001F, 16'h0);
    @(posedge clk); @(negedge clk);
    checks++; if (memRq !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_in_access: got memRq=%b busy=%b, expected 1/1", memRq, busy); else passed++;
    rst_n = 1'b0;
    setPort(0, 1'b0, 1'b1, 16'h0, 16'h0);
    @(posedge clk); @(negedge clk);
    checks++; if (memRq !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_abort: got memRq=%b busy=%b, expected 0/0", memRq, busy); else passed++;
    checks++; if (p0_rdata !== 16'h0) $display("FAIL midrst_rdata: got %h, expected 0000", p0_rdata); else passed++;
    rst_n = 1'b1;
    refRdata[0] = 16'h0; refRdata[1] = 16'h0;
    for (int i = 0; i < AC + 3; i++) begin
      if (p0_ack || p1_ack) stray++;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (stray != 0) $display("FAIL midrst_no_ack: got %0d, expected 0", stray); else passed++;
    runAccess(0, 1'b1, 16'h001F, 16'h0, 1'b0, lat, rq, acks, oth, rd, ok, gid);
    refRdata[0] = 16'h0055;
    checks++; if (rd !== 16'h0055 || lat != AC + 1) $display("FAIL midrst_fresh_read: got %h lat %0d, expected 0055 lat %0d", rd, lat, AC + 1); else passed++;
  endtask

  task automatic test_random();
    int lat, rq, acks, oth, port; logic [15:0] rd, a, d, expRd, other; bit ok, drop; logic gid, rnw;
    for (int n = 0; n < 24; n++) begin
      port = $urandom_range(0, 1);
      rnw  = 1'($urandom_range(0, 1));
      a    = 16'h0080 + 16'($urandom_range(0, 15));
      d    = 16'($urandom);
      drop = 1'($urandom_range(0, 1));
      runAccess(port, rnw, a, d, drop, lat, rq, acks, oth, rd, ok, gid);
      if (rnw) begin
        expRd = refMem.exists(int'(a)) ? refMem[int'(a)] : 16'h0;
        refRdata[port] = expRd;
      end else begin
        expRd = refRdata[port];
        refMem[int'(a)] = d;
      end
      other = (port == 0) ? p1_rdata : p0_rdata;
      checks++; if (lat != AC + 1) $display("FAIL rand_latency #%0d: got %0d, expected %0d", n, lat, AC + 1); else passed++;
      checks++; if (rq != AC || !ok) $display("FAIL rand_bus #%0d: got %0d cycles ok=%b, expected %0d ok=1", n, rq, ok, AC); else passed++;
      checks++; if (acks != 1 || oth != 0) $display("FAIL rand_acks #%0d: got %0d/%0d, expected 1/0", n, acks, oth); else passed++;
      checks++; if (gid !== 1'(port)) $display("FAIL rand_grant_id #%0d: got %b, expected %0d", n, gid, port); else passed++;
      checks++; if (rd !== expRd) $display("FAIL rand_rdata #%0d: got %h, expected %h", n, rd, expRd); else passed++;
      checks++; if (other !== refRdata[1 - port]) $display("FAIL rand_other_rdata #%0d: got %h, expected %h", n, other, refRdata[1 - port]); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 16'h0;
    rst_n = 1'b0;
    setPort(0, 1'b0, 1'b1, 16'h0, 16'h0);
    setPort(1, 1'b0, 1'b1, 16'h0, 16'h0);
    test_reset();
    test_p0_write_read();
    test_p1_access();
    test_contention();
    test_drop_req();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
